// File: rtl/uart_tx_arbiter_pkg.sv
// Shared sensor/UART definitions: arbiter FSM encoding, FIFO word layout and defaults.
package uart_tx_arbiter_pkg;

   localparam int         DEPTH_DEFAULT = 16;
   localparam logic [7:0] ASCII_LF      = 8'h0A;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_HOLD      = 3'd4
   } arb_state_t;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } fifo_word_t;

endpackage

// File: rtl/byte_fifo.sv
// Per-source synchronous FIFO of {last,data} words with a sticky drop flag.
module byte_fifo
   import uart_tx_arbiter_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  fifo_word_t wr_word,
   input  logic       rd_en,
   output fifo_word_t rd_word,
   output logic       full,
   output logic       empty,
   output logic       ovf
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   fifo_word_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_wr;
   logic          do_rd;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   // Full is judged on the pre-pop occupancy, so a same-cycle pop never rescues a write.
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_en && full) ovf <= 1'b1;
      end
   end

   // NOTE: storage has no reset; the pointers alone define validity, keeping it RAM-inferable.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_word;
   end

   assign rd_word = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-source message arbiter feeding one UART transmitter; messages are never interleaved.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s0_data,
   input  logic       s0_valid,
   input  logic       s0_last,
   input  logic [7:0] s1_data,
   input  logic       s1_valid,
   input  logic       s1_last,
   output logic       s0_full,
   output logic       s1_full,
   output logic       ovf0,
   output logic       ovf1,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic       grant,
   output logic       active
);

   arb_state_t state_q;
   arb_state_t state_d;
   logic       grant_d;
   logic       last_served_q;
   logic       last_q;
   fifo_word_t head0;
   fifo_word_t head1;
   fifo_word_t head_cur;
   fifo_word_t head_next;
   logic       empty0;
   logic       empty1;
   logic       cur_empty;
   logic       pop0;
   logic       pop1;

   byte_fifo #(.DEPTH(DEPTH)) u_fifo0 (
      .clk(clk), .rst(rst), .wr_en(s0_valid), .wr_word({s0_last, s0_data}),
      .rd_en(pop0), .rd_word(head0), .full(s0_full), .empty(empty0), .ovf(ovf0)
   );

   byte_fifo #(.DEPTH(DEPTH)) u_fifo1 (
      .clk(clk), .rst(rst), .wr_en(s1_valid), .wr_word({s1_last, s1_data}),
      .rd_en(pop1), .rd_word(head1), .full(s1_full), .empty(empty1), .ovf(ovf1)
   );

   assign head_cur  = grant   ? head1  : head0;
   assign head_next = grant_d ? head1  : head0;
   assign cur_empty = grant   ? empty1 : empty0;
   assign tx_start  = (state_q == ST_LAUNCH);
   assign active    = (state_q != ST_IDLE);
   assign pop0      = tx_start && !grant;
   assign pop1      = tx_start &&  grant;

   // NOTE: defaults first, so every path assigns every output and no latch is inferred.
   always_comb begin
      state_d = state_q;
      grant_d = grant;
      case (state_q)
         ST_IDLE: begin
            if (!empty0 || !empty1) begin
               state_d = ST_LAUNCH;
               grant_d = (!empty0 && !empty1) ? !last_served_q : empty0;
            end
         end
         ST_LAUNCH:    state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (tx_busy) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_q)          state_d = ST_IDLE;
               else if (!cur_empty) state_d = ST_LAUNCH;
               else                 state_d = ST_HOLD;
            end
         end
         ST_HOLD:      if (!cur_empty) state_d = ST_LAUNCH;
         default:      state_d = ST_IDLE;
      endcase
   end

   // tx_data is loaded on the edge entering LAUNCH so it is valid alongside tx_start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         grant         <= 1'b0;
         last_served_q <= 1'b1;
         last_q        <= 1'b0;
         tx_data       <= 8'h00;
      end else begin
         state_q <= state_d;
         grant   <= grant_d;
         if (state_d == ST_LAUNCH) tx_data <= head_next.data;
         if (state_q == ST_LAUNCH) last_q <= head_cur.last;
         if (state_q == ST_WAIT_DONE && state_d == ST_IDLE) last_served_q <= grant;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: arbitration table, directed multi-cycle sequences, randomized traffic.
module tb_uart_tx_arbiter;
   import uart_tx_arbiter_pkg::*;

   localparam int DEPTH = DEPTH_DEFAULT;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s0_data, s1_data;
   logic       s0_valid, s1_valid, s0_last, s1_last;
   logic       s0_full, s1_full, ovf0, ovf1;
   logic [7:0] tx_data;
   logic       tx_start, grant, active;
   logic       tx_busy = 1'b0;

   uart_tx_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last),
      .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last),
      .s0_full(s0_full), .s1_full(s1_full), .ovf0(ovf0), .ovf1(ovf1),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .grant(grant), .active(active)
   );

   always #5 clk = ~clk;

   int         pass_cnt = 0;
   int         check_cnt = 0;
   int         cyc = 0;
   int         busy_len = 3;
   int         busy_cnt = 0;
   logic       hold_busy = 1'b0;
   logic [7:0] log_data[$];
   logic       log_src[$];
   int         log_cyc[$];
   int         sent_n[2];
   int         rem[2];
   int         wn[2];
   logic [8:0] exp0[$];
   logic [8:0] exp1[$];

   // UART model and launch monitor, evaluated on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (tx_start === 1'b1) begin
         log_data.push_back(tx_data);
         log_src.push_back(grant);
         log_cyc.push_back(cyc);
         sent_n[grant]++;
         busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
      tx_busy = hold_busy || (busy_cnt != 0);
   end

   typedef struct {
      int n0;
      int n1;
      int skew;
      int exp_first;
   } vec_t;

   vec_t vecs[7];

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic drive0(input logic v, input logic [7:0] d, input logic l);
      s0_valid = v; s0_data = d; s0_last = l;
   endtask

   task automatic drive1(input logic v, input logic [7:0] d, input logic l);
      s1_valid = v; s1_data = d; s1_last = l;
   endtask

   task automatic idle_inputs();
      drive0(1'b0, 8'h00, 1'b0);
      drive1(1'b0, 8'h00, 1'b0);
   endtask

   task automatic log_clear();
      log_data.delete();
      log_src.delete();
      log_cyc.delete();
      sent_n[0] = 0;
      sent_n[1] = 0;
   endtask

   task automatic wait_starts(input int n, input int budget, input string name);
      for (int i = 0; i < budget && log_data.size() < n; i++) step();
      check(name, log_data.size(), n);
   endtask

   task automatic wait_idle(input int budget, input string name);
      for (int i = 0; i < budget && active !== 1'b0; i++) step();
      check(name, active, 1'b0);
   endtask

   task automatic check_entry(input string name, input int i, input logic s, input logic [7:0] d);
      if (i < log_data.size()) check($sformatf("%s[%0d]", name, i), {log_src[i], log_data[i]}, {s, d});
      else check($sformatf("%s[%0d] missing", name, i), log_data.size(), i + 1);
   endtask

   task automatic run_row(input int r, input vec_t v);
      int         o0 = (v.skew < 0) ? -v.skew : 0;
      int         o1 = (v.skew > 0) ?  v.skew : 0;
      int         span = (o0 + v.n0 > o1 + v.n1) ? o0 + v.n0 : o1 + v.n1;
      logic [7:0] d0[$];
      logic [7:0] d1[$];
      logic [7:0] ed[$];
      logic       es[$];
      log_clear();
      for (int c = 0; c < span; c++) begin
         drive0(c >= o0 && c < o0 + v.n0, 8'(8'h30 + r*8 + c - o0), c == o0 + v.n0 - 1);
         drive1(c >= o1 && c < o1 + v.n1, 8'(8'h34 + r*8 + c - o1), c == o1 + v.n1 - 1);
         if (s0_valid) d0.push_back(s0_data);
         if (s1_valid) d1.push_back(s1_data);
         step();
      end
      idle_inputs();
      if (v.exp_first == 0) begin
         foreach (d0[i]) begin ed.push_back(d0[i]); es.push_back(1'b0); end
         foreach (d1[i]) begin ed.push_back(d1[i]); es.push_back(1'b1); end
      end else begin
         foreach (d1[i]) begin ed.push_back(d1[i]); es.push_back(1'b1); end
         foreach (d0[i]) begin ed.push_back(d0[i]); es.push_back(1'b0); end
      end
      wait_starts(ed.size(), 400, $sformatf("row%0d starts", r));
      wait_idle(100, $sformatf("row%0d idle", r));
      check($sformatf("row%0d count", r), log_data.size(), ed.size());
      foreach (ed[i]) check_entry($sformatf("row%0d byte", r), i, es[i], ed[i]);
   endtask

   task automatic test_a();
      logic [7:0] msg[7];
      int         wc;
      msg = '{8'h31, 8'h32, 8'h2E, 8'h33, 8'h34, 8'h6D, ASCII_LF};
      busy_len = 20;
      log_clear();
      wc = cyc;
      for (int i = 0; i < 7; i++) begin
         drive0(1'b1, msg[i], i == 6);
         step();
      end
      idle_inputs();
      wait_starts(7, 300, "A starts");
      if (log_cyc.size() > 0) check("A first latency", log_cyc[0] - wc, 2);
      for (int i = 0; i < 7; i++) check_entry("A byte", i, 1'b0, msg[i]);
      for (int i = 0; i < 100 && tx_busy; i++) step();
      check("A busy falls", tx_busy, 1'b0);
      check("A active at busy fall", active, 1'b1);
      step();
      check("A active dropped", active, 1'b0);
      check("A tx_data held", tx_data, ASCII_LF);
      check("A start count", log_data.size(), 7);
   endtask

   task automatic test_d();
      busy_len = 3;
      log_clear();
      for (int i = 0; i < 2; i++) begin
         drive1(1'b1, 8'(8'hD0 + i), 1'b0);
         step();
      end
      idle_inputs();
      for (int c = 0; c < 50; c++) begin
         if (c == 10)      drive0(1'b1, 8'hA0, 1'b0);
         else if (c == 11) drive0(1'b1, 8'hA1, 1'b1);
         else              drive0(1'b0, 8'h00, 1'b0);
         step();
      end
      check("D hold starts", log_data.size(), 2);
      check("D hold active", active, 1'b1);
      check("D hold grant", grant, 1'b1);
      drive1(1'b1, 8'hD2, 1'b1);
      step();
      idle_inputs();
      wait_starts(5, 200, "D starts");
      wait_idle(100, "D idle");
      check_entry("D byte", 0, 1'b1, 8'hD0);
      check_entry("D byte", 1, 1'b1, 8'hD1);
      check_entry("D byte", 2, 1'b1, 8'hD2);
      check_entry("D byte", 3, 1'b0, 8'hA0);
      check_entry("D byte", 4, 1'b0, 8'hA1);
   endtask

   task automatic test_c();
      busy_len = 3;
      hold_busy = 1'b1;
      log_clear();
      drive1(1'b1, 8'hC0, 1'b1);
      step();
      idle_inputs();
      wait_starts(1, 20, "C s1 start");
      for (int i = 0; i < DEPTH + 2; i++) begin
         drive0(1'b1, 8'(8'h80 + i), i >= DEPTH - 1);
         step();
         if (i == DEPTH - 2) check("C not full yet", s0_full, 1'b0);
         if (i == DEPTH - 1) begin
            check("C full at DEPTH", s0_full, 1'b1);
            check("C no ovf yet", ovf0, 1'b0);
         end
      end
      idle_inputs();
      check("C ovf0 set", ovf0, 1'b1);
      check("C ovf1 clear", ovf1, 1'b0);
      hold_busy = 1'b0;
      wait_starts(DEPTH + 1, DEPTH * 20, "C starts");
      wait_idle(100, "C idle");
      check("C count", log_data.size(), DEPTH + 1);
      check_entry("C byte", 0, 1'b1, 8'hC0);
      for (int i = 0; i < DEPTH; i++) check_entry("C byte", i + 1, 1'b0, 8'(8'h80 + i));
      check("C drained", s0_full, 1'b0);
      check("C ovf0 sticky", ovf0, 1'b1);
   endtask

   task automatic test_e();
      busy_len = 20;
      log_clear();
      for (int i = 0; i < 6; i++) begin
         drive0(1'b1, 8'(8'hE0 + i), i == 5);
         step();
      end
      idle_inputs();
      step();
      check("E pre active", active, 1'b1);
      check("E pre starts", log_data.size(), 1);
      rst = 1'b1;
      step();
      check("E rst active", active, 1'b0);
      check("E rst tx_start", tx_start, 1'b0);
      check("E rst tx_data", tx_data, 8'h00);
      check("E rst grant", grant, 1'b0);
      check("E rst flags", {s0_full, s1_full, ovf0, ovf1}, 4'b0000);
      rst = 1'b0;
      repeat (60) step();
      check("E no starts after rst", log_data.size(), 1);
      check("E still idle", active, 1'b0);
      log_clear();
      drive0(1'b1, 8'h51, 1'b1);
      drive1(1'b1, 8'h52, 1'b1);
      step();
      idle_inputs();
      wait_starts(2, 100, "E tie starts");
      wait_idle(100, "E tie idle");
      check_entry("E tie", 0, 1'b0, 8'h51);
      check_entry("E tie", 1, 1'b1, 8'h52);
   endtask

   task automatic rand_src(input int s, input logic allow_new,
                           output logic v, output logic [7:0] d, output logic l);
      v = 1'b0; d = 8'h00; l = 1'b0;
      if (rem[s] == 0 && allow_new && $urandom_range(0, 9) == 0) rem[s] = $urandom_range(1, 4);
      if (rem[s] > 0 && $urandom_range(0, 2) != 0 && (wn[s] - sent_n[s]) < DEPTH - 2) begin
         v = 1'b1;
         d = 8'($urandom_range(0, 255));
         l = (rem[s] == 1);
         rem[s]--;
         wn[s]++;
         if (s == 0) exp0.push_back({l, d});
         else        exp1.push_back({l, d});
      end
   endtask

   task automatic test_random();
      logic       v;
      logic [7:0] d;
      logic       l;
      logic       in_msg = 1'b0;
      logic       cur = 1'b0;
      logic [8:0] w;
      int         cnt0 = 0;
      int         cnt1 = 0;
      busy_len = $urandom_range(1, 4);
      log_clear();
      exp0.delete();
      exp1.delete();
      rem = '{0, 0};
      wn = '{0, 0};
      for (int c = 0; c < 3000; c++) begin
         if (c >= 1500 && rem[0] == 0 && rem[1] == 0) break;
         rand_src(0, c < 1500, v, d, l);
         drive0(v, d, l);
         rand_src(1, c < 1500, v, d, l);
         drive1(v, d, l);
         step();
      end
      idle_inputs();
      wait_starts(wn[0] + wn[1], (wn[0] + wn[1]) * 20 + 100, "R starts");
      wait_idle(200, "R idle");
      foreach (log_src[i]) if (log_src[i]) cnt1++; else cnt0++;
      check("R count src0", cnt0, wn[0]);
      check("R count src1", cnt1, wn[1]);
      foreach (log_data[i]) begin
         if (in_msg) check($sformatf("R no interleave[%0d]", i), log_src[i], cur);
         if (log_src[i] == 1'b0 && exp0.size() > 0) w = exp0.pop_front();
         else if (log_src[i] == 1'b1 && exp1.size() > 0) w = exp1.pop_front();
         else continue;
         check($sformatf("R data[%0d]", i), log_data[i], w[7:0]);
         in_msg = !w[8];
         cur = log_src[i];
      end
      check("R no overflow", {ovf0, ovf1}, 2'b00);
   endtask

   initial begin
      vecs[0] = '{3, 3,  0, 0};
      vecs[1] = '{2, 0,  0, 0};
      vecs[2] = '{3, 2,  0, 1};
      vecs[3] = '{1, 4,  0, 1};
      vecs[4] = '{2, 2,  2, 0};
      vecs[5] = '{2, 3, -3, 1};
      vecs[6] = '{4, 4,  0, 1};

      idle_inputs();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      check("reset active", active, 1'b0);
      check("reset tx_start", tx_start, 1'b0);
      check("reset tx_data", tx_data, 8'h00);
      check("reset grant", grant, 1'b0);
      check("reset flags", {s0_full, s1_full, ovf0, ovf1}, 4'b0000);

      for (int r = 0; r < 7; r++) run_row(r, vecs[r]);

      test_a();
      test_d();
      test_c();
      test_e();
      test_random();

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DEPTH, default 16, is the per-source FIFO depth in entries and SHALL be a power of two, minimum 4.
REQ-002 clk  input  1  system clock; the single clock of the block.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 s0_data / s1_data  input  8  ASCII byte from source 0 (sr04 text) / source 1 (second sensor or clock text).
REQ-005 s0_valid / s1_valid  input  1  one-cycle byte strobe; the source cannot stall.
REQ-006 s0_last / s1_last  input  1  qualifies the byte as the final byte of its message.
REQ-007 s0_full / s1_full  output  1  the source FIFO holds DEPTH entries.
REQ-008 ovf0 / ovf1  output  1  sticky flag: a byte was dropped on that source.
REQ-009 tx_data  output  8  byte to the UART transmitter, registered.
REQ-010 tx_start  output  1  one-cycle launch pulse to the UART transmitter.
REQ-011 tx_busy  input  1  UART transmitter busy, high for the duration of a frame.
REQ-012 grant  output  1  index of the source owning the transmitter; meaningful only while active=1.
REQ-013 active  output  1  a message is being transmitted.

Function
REQ-014 Each source SHALL have a DEPTH-entry, 9-bit ({last,data}) synchronous FIFO; the write is accepted when valid=1 and full=0.
REQ-015 A write when full=0 is false (valid=1, full=1) SHALL drop the byte and set ovfN; a pop in the same cycle SHALL NOT unblock the write.
REQ-016 A simultaneous write and pop on a non-full FIFO SHALL both succeed, leaving the occupancy unchanged.
REQ-017 The FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE and HOLD.
REQ-018 IDLE: when any FIFO is non-empty, the FSM SHALL lock grant and go to LAUNCH next cycle.
REQ-019 IDLE arbitration: if both FIFOs are non-empty, the source not served last SHALL be granted; otherwise the non-empty source SHALL be granted.
REQ-020 LAUNCH (exactly 1 cycle): the FSM SHALL pop the head of the granted FIFO, drive tx_data=head data with tx_start=1, latch the head's last bit, and go to WAIT_BUSY.
REQ-021 WAIT_BUSY: when tx_busy=1 the FSM SHALL go to WAIT_DONE; tx_start SHALL stay 0.
REQ-022 WAIT_DONE, on tx_busy=0 with latched last=1: the FSM SHALL go to IDLE, set last_served=grant and drop active.
REQ-023 WAIT_DONE, on tx_busy=0 with latched last=0: the FSM SHALL go to LAUNCH if the granted FIFO is non-empty, else to HOLD.
REQ-024 HOLD: the FSM SHALL keep the grant and go to LAUNCH when the granted FIFO becomes non-empty; the other source never preempts a message mid-stream.
REQ-025 active SHALL be 1 in every state except IDLE.
REQ-026 tx_data SHALL hold its value until the next LAUNCH.
REQ-027 Bytes SHALL be transmitted in write order per source, with no interleaving of the two sources within one message.
REQ-028 Minimum latency: a write into empty FIFOs in cycle N SHALL give IDLE decision in N+1, tx_start in N+2.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL reset to: state=IDLE, both FIFOs empty, ovf0=ovf1=0, tx_start=0, tx_data=0x00, grant=0, active=0, last_served=1 (so source 0 wins the first tie).
REQ-030 Reset mid-message SHALL discard all buffered bytes with no further tx_start; a frame already launched completes in the UART, outside this block.

Structure
REQ-031 FSM state encoding, DEPTH default and ASCII_LF (0x0A) SHALL live in the shared sensor/UART package.
REQ-032 The FIFO SHALL be one sub-module, byte_fifo, instantiated twice; arbitration and FSM stay in uart_tx_arbiter.

Verification
REQ-033 Test A: source 0 writes "12.34m\n" back-to-back (last on '\n'), UART model busy 20 cycles per byte -> 7 tx_start pulses, bytes in order, grant=0, active drops after the final busy falls.
REQ-034 Test B: both sources write 3-byte messages in the same cycle after reset -> source 0's message is sent entirely first, then source 1's; a repeat tie grants source 1 first.
REQ-035 Test C: source 0 writes DEPTH+2 bytes back-to-back with a busy-held UART -> s0_full=1 after DEPTH writes, 2 bytes dropped, ovf0=1, first DEPTH bytes transmitted intact.
REQ-036 Test D: source 1 sends 2 bytes without last, then idles 50 cycles, then sends the last byte; source 0 writes meanwhile -> FSM sits in HOLD, source 0 waits, the third byte follows, then source 0 is served.
REQ-037 Test E: rst asserted while in WAIT_DONE with 5 bytes queued -> next cycle all outputs at reset values, no further tx_start, FIFOs empty.
